// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, controller states and lane/extension helpers for data_mem_ctrl
package mem_pkg;
  typedef enum logic [2:0] {F3_B = 3'd0, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU} funct3_e;
  typedef enum logic {ST_IDLE, ST_SPLIT} state_e;
  function automatic logic [3:0] nbytes(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction
  function automatic logic f3_legal(input logic [2:0] f3, input logic st, input logic is64);
    return st ? (f3 == F3_B || f3 == F3_H || f3 == F3_W || (is64 && f3 == F3_D))
              : (f3 != 3'd7 && ((f3 != F3_D && f3 != F3_WU) || is64));
  endfunction
  // byte-lane mask across a two-word window, so a split access yields both beats' lanes
  function automatic logic [15:0] lane_mask(input logic [2:0] f3, input logic [2:0] off);
    return ((16'd1 << nbytes(f3)) - 16'd1) << off;
  endfunction
  function automatic logic [63:0] extend(input logic [63:0] raw, input logic [2:0] f3);
    return f3 == F3_B  ? {{56{raw[7]}}, raw[7:0]} :
           f3 == F3_H  ? {{48{raw[15]}}, raw[15:0]} :
           f3 == F3_W  ? {{32{raw[31]}}, raw[31:0]} :
           f3 == F3_BU ? {56'd0, raw[7:0]} :
           f3 == F3_HU ? {48'd0, raw[15:0]} :
           f3 == F3_WU ? {32'd0, raw[31:0]} : raw;
  endfunction
endpackage

// File: rtl/ram_bytelane.sv
// ram_bytelane: DEPTH x SIZE synchronous RAM with per-byte write enables and registered read
module ram_bytelane #(
  parameter int DEPTH = 1024,
  parameter int SIZE  = 32
) (
  input  logic                     clock_i,
  input  logic [SIZE/8-1:0]        we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [SIZE-1:0]          wdata_i,
  output logic [SIZE-1:0]          rdata_o
);
  logic [SIZE-1:0] mem_q [DEPTH];
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < SIZE/8; i++)
      if (we_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed load/store memory with size decode, extension, fault checks and misaligned split
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH      = 1024,
  parameter int SIZE           = 32,
  parameter int BASE_ADDR      = 0,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            req_i,
  input  logic            wren_i,
  input  logic [2:0]      funct3_i,
  input  logic [SIZE-1:0] address_i,
  input  logic [SIZE-1:0] data_i,
  output logic            ready_o,
  output logic            done_o,
  output logic            fault_o,
  output logic [SIZE-1:0] salida_o
);
  localparam int L  = SIZE/8;
  localparam int LB = $clog2(L);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int ML = 2*L;
  state_e state_q, state_d;
  logic done_q, fault_q, wren_q, split_q, below, split, flt, acc;
  logic [2:0] f3_q;
  logic [LB-1:0] off, off_q;
  logic [AW-1:0] idx_q, ram_addr;
  logic [SIZE-1:0] rel, idx, rdata, buf_q, win, ram_wdata;
  logic [4:0] end_b;
  logic [ML-1:0] m_new;
  logic [L-1:0] hi_we_q, we;
  logic [2*SIZE-1:0] wide;
  assign ready_o = state_q == ST_IDLE && !reset_i;
  assign acc = req_i && ready_o;
  assign {below, rel} = {1'b0, address_i} - {1'b0, SIZE'(BASE_ADDR)};
  assign idx = rel >> LB;
  assign off = address_i[LB-1:0];
  assign end_b = 5'(off) + 5'(nbytes(funct3_i));
  assign split = end_b > 5'(L);
  assign flt = !f3_legal(funct3_i, wren_i, SIZE == 64) || below || idx >= SIZE'(MEM_DEPTH) ||
               (split && (idx + SIZE'(1) >= SIZE'(MEM_DEPTH) || MISALIGN_SPLIT == 0));
  assign m_new = ML'(lane_mask(funct3_i, 3'(off)));
  assign wide = {{SIZE{1'b0}}, data_i} << {off, 3'b000};
  assign ram_addr = state_q == ST_SPLIT ? idx_q + AW'(1) : idx[AW-1:0];
  assign ram_wdata = state_q == ST_SPLIT ? buf_q : wide[SIZE-1:0];
  // a reset landing on the second beat must suppress its write
  assign we = state_q == ST_SPLIT ? (wren_q && !reset_i ? hi_we_q : '0)
                                  : (acc && wren_i && !flt ? m_new[L-1:0] : '0);
  assign win = SIZE'({rdata, split_q ? buf_q : rdata} >> {off_q, 3'b000});
  assign salida_o = done_q && !wren_q && !fault_q ? SIZE'(extend(64'(win), f3_q)) : '0;
  assign done_o = done_q;
  assign fault_o = fault_q;
  ram_bytelane #(.DEPTH(MEM_DEPTH), .SIZE(SIZE)) u_ram (
    .clock_i(clock_i), .we_i(we), .addr_i(ram_addr), .wdata_i(ram_wdata), .rdata_o(rdata)
  );
  always_comb begin
    state_d = state_q;
    if (state_q == ST_SPLIT) state_d = ST_IDLE;
    else if (acc && split && !flt) state_d = ST_SPLIT;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      wren_q  <= 1'b0;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= state_q == ST_SPLIT || (acc && (flt || !split));
      fault_q <= acc && flt;
      if (acc) begin
        wren_q  <= wren_i;
        f3_q    <= funct3_i;
        off_q   <= off;
        idx_q   <= idx[AW-1:0];
        split_q <= split && !flt;
        hi_we_q <= m_new[ML-1:L];
        buf_q   <= wide[2*SIZE-1:SIZE];
      end else if (state_q == ST_SPLIT && !wren_q) buf_q <= rdata;
    end
  end
endmodule
